// File: rtl/encoder4to2_hs_pkg.sv
// Shared constants, FSM state type and helpers for the 4-to-2 handshake encoder.
package enc4_pkg;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned CODE_W = 2;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    function automatic logic [2:0] popcount4(input logic [NREQ-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/encoder4to2_hs_if.sv
// Request capture and valid/ready code handshake bundle for encoder4to2_hs.
interface encoder4to2_hs_if;
    import enc4_pkg::*;

    logic              en;
    logic [NREQ-1:0]   req;
    logic              ready;
    logic              valid;
    logic [CODE_W-1:0] code;
    logic              multi;

    modport master (
        output en, req, ready,
        input  valid, code, multi
    );

    modport slave (
        input  en, req, ready,
        output valid, code, multi
    );

endinterface

// File: rtl/encoder4to2_hs_prio_sel4.sv
// Combinational 4-input priority selector; direction chosen by hi_wins.
module prio_sel4
    import enc4_pkg::*;
(
    input  logic [NREQ-1:0]   vec,
    input  logic              hi_wins,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    // Last matching assignment wins: ascending scan keeps the highest set
    // index, descending scan keeps the lowest.
    always_comb begin
        idx = '0;
        any = |vec;
        if (hi_wins) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (vec[i]) idx = CODE_W'(i);
            end
        end else begin
            for (int unsigned i = NREQ; i > 0; i--) begin
                if (vec[i-1]) idx = CODE_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/encoder4to2_hs.sv
// Sequential 4-to-2 priority encoder: latches request pulses, presents the
// winning index over valid/ready and counts requests that hit a pending bit.
module encoder4to2_hs
    import enc4_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter bit          HI_WINS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    encoder4to2_hs_if.slave   bus,
    output logic [NREQ-1:0]   pending,
    output logic [CNT_W-1:0]  drop_cnt
);

    state_t            state, state_nxt;
    logic [CODE_W-1:0] code_q, code_nxt;
    logic              multi_q, multi_nxt;
    logic              accept;
    logic [NREQ-1:0]   set_vec, clr_vec, drop_vec, pending_nxt;
    logic [CODE_W-1:0] sel_idx;
    logic              sel_any;

    prio_sel4 u_sel (
        .vec     (pending),
        .hi_wins (HI_WINS),
        .idx     (sel_idx),
        .any     (sel_any)
    );

    // A set on the same edge as the handshake clear wins and is not a drop.
    always_comb begin
        accept  = (state == ST_HOLD) && bus.ready;
        clr_vec = '0;
        if (accept) clr_vec[code_q] = 1'b1;
        set_vec     = bus.en ? bus.req : '0;
        drop_vec    = set_vec & pending & ~clr_vec;
        pending_nxt = (pending & ~clr_vec) | set_vec;
    end

    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        multi_nxt = multi_q;
        case (state)
            ST_IDLE: begin
                if (sel_any) begin
                    code_nxt  = sel_idx;
                    multi_nxt = popcount4(pending) > 3'd1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            code_q  <= '0;
            multi_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            code_q  <= code_nxt;
            multi_q <= multi_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            drop_cnt <= '0;
        end else begin
            pending <= pending_nxt;
            if ((|drop_vec) && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    assign bus.valid = (state == ST_HOLD);
    assign bus.code  = code_q;
    assign bus.multi = multi_q;

endmodule

// File: tb/tb_encoder4to2_hs.sv
// Scoreboard bench for encoder4to2_hs: two instances (hi-wins/8-bit counter and
// lo-wins/2-bit counter) share stimulus; a cycle model predicts every code.
module tb_encoder4to2_hs;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic       ready;
    logic [3:0] pend_a, pend_b;
    logic [7:0] drop_a;
    logic [1:0] drop_b;

    int checks = 0;
    int errors = 0;

    encoder4to2_hs_if bus_a ();
    encoder4to2_hs_if bus_b ();

    assign bus_a.en = en;
    assign bus_a.req = req;
    assign bus_a.ready = ready;
    assign bus_b.en = en;
    assign bus_b.req = req;
    assign bus_b.ready = ready;

    encoder4to2_hs #(.CNT_W(8), .HI_WINS(1'b1)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_a),
        .pending  (pend_a),
        .drop_cnt (drop_a)
    );

    encoder4to2_hs #(.CNT_W(2), .HI_WINS(1'b0)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_b),
        .pending  (pend_b),
        .drop_cnt (drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, one slot per instance.
    bit [3:0] m_pend[2];
    bit       m_hold[2];
    bit [1:0] m_code[2];
    int       m_drop[2];
    bit       hi_of[2]  = '{1'b1, 1'b0};
    int       max_of[2] = '{255, 3};
    logic [2:0] q0[$];
    logic [2:0] q1[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = '0;
            m_hold[i] = 1'b0;
            m_code[i] = '0;
            m_drop[i] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic [3:0] old, nw;
            bit acc, dropped;
            int c;
            old = m_pend[i];
            nw = old;
            acc = m_hold[i] && ready;
            dropped = 1'b0;
            if (acc) nw[m_code[i]] = 1'b0;
            if (en) begin
                for (int k = 0; k < 4; k++) begin
                    if (req[k]) begin
                        if (nw[k]) dropped = 1'b1;
                        nw[k] = 1'b1;
                    end
                end
            end
            if (!m_hold[i]) begin
                if (old != 4'd0) begin
                    if (hi_of[i]) c = $clog2(int'(old) + 1) - 1;
                    else c = $clog2(int'(old & (~old + 4'd1)));
                    m_code[i] = 2'(c);
                    m_hold[i] = 1'b1;
                    if (i == 0) q0.push_back({2'(c), $countones(old) > 1});
                    else q1.push_back({2'(c), $countones(old) > 1});
                end
            end else if (ready) begin
                m_hold[i] = 1'b0;
            end
            if (dropped && m_drop[i] < max_of[i]) m_drop[i]++;
            m_pend[i] = nw;
        end
    endtask

    task automatic check_inst(input int i, input logic v, input logic [1:0] c, input logic m,
                              input logic [3:0] p, input int d);
        logic [2:0] exp;
        logic [3:0] dec, want;
        chk($sformatf("valid[%0d]", i), v, m_hold[i]);
        chk($sformatf("pending[%0d]", i), p, m_pend[i]);
        chk($sformatf("drop_cnt[%0d]", i), d, m_drop[i]);
        if (v === 1'b1 && ready) begin
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer[%0d]: got code %0d expected no transfer", i, c);
            end else begin
                exp = (i == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("code[%0d]", i), c, exp[2:1]);
                chk($sformatf("multi[%0d]", i), m, exp[0]);
                // behavioural 2-to-4 decoder: i0 = code[1], i1 = code[0], en = valid
                dec  = v ? (4'b0001 << {c[1], c[0]}) : 4'b0000;
                want = 4'b0001 << exp[2:1];
                chk($sformatf("roundtrip[%0d]", i), dec, want);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_inst(0, bus_a.valid, bus_a.code, bus_a.multi, pend_a, int'(drop_a));
            check_inst(1, bus_b.valid, bus_b.code, bus_b.multi, pend_b, int'(drop_b));
        end
    end

    task automatic cycle(input logic e, input logic [3:0] r, input logic rd);
        en = e;
        req = r;
        ready = rd;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic flush();
        for (int n = 0; n < 12; n++) cycle(1'b0, 4'b0000, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid_a", bus_a.valid, 0);
        chk("rst_code_a", bus_a.code, 0);
        chk("rst_multi_a", bus_a.multi, 0);
        chk("rst_pending_a", pend_a, 0);
        chk("rst_drop_a", drop_a, 0);
        chk("rst_valid_b", bus_b.valid, 0);
        chk("rst_pending_b", pend_b, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        en = 1'b0;
        req = '0;
        ready = 1'b0;
        #2;
        do_reset();

        // single request, 2-edge latency then one bubble
        cycle(1'b1, 4'b0100, 1'b1);
        chk("single_lat_valid0", bus_a.valid, 0);
        chk("single_pending", pend_a, 4'b0100);
        cycle(1'b0, 4'b0000, 1'b1);
        chk("single_valid", bus_a.valid, 1);
        chk("single_code", bus_a.code, 2);
        chk("single_multi", bus_a.multi, 0);
        cycle(1'b0, 4'b0000, 1'b1);
        chk("single_bubble", bus_a.valid, 0);
        chk("single_cleared", pend_a, 0);
        flush();

        // multi-hot burst drains in priority order
        cycle(1'b1, 4'b1011, 1'b1);
        flush();

        // backpressure holds code 01 against a newer higher request
        cycle(1'b1, 4'b0011, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);
        for (int n = 0; n < 5; n++) begin
            cycle(n == 1, 4'b1000, 1'b0);
            chk("bp_code_hold", bus_a.code, 1);
        end
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        chk("bp_next_code", bus_a.code, 3);
        flush();

        // reset in the middle of a HOLD with pending = 1010
        cycle(1'b1, 4'b1010, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);
        chk("pre_rst_valid", bus_a.valid, 1);
        do_reset();

        // drops and saturation
        cycle(1'b1, 4'b0100, 1'b0);
        for (int n = 0; n < 3; n++) begin
            cycle(1'b1, 4'b0100, 1'b0);
            cycle(1'b0, 4'b0000, 1'b0);
        end
        chk("drop3_a", drop_a, 3);
        chk("drop3_b", drop_b, 3);
        for (int n = 0; n < 2; n++) cycle(1'b1, 4'b0100, 1'b0);
        chk("drop5_a", drop_a, 5);
        chk("drop_sat_b", drop_b, 3);
        cycle(1'b0, 4'b1111, 1'b0);
        chk("en_low_pending", pend_a, 4'b0100);
        chk("en_low_drop", drop_a, 5);

        // clear and set of the same bit on one edge
        cycle(1'b1, 4'b0100, 1'b1);
        chk("clrset_pending", pend_a, 4'b0100);
        chk("clrset_drop", drop_a, 5);
        flush();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            cycle(($urandom % 4) != 0, ($urandom % 4 == 0) ? 4'($urandom) : 4'b0000,
                  ($urandom % 3) != 0);
        end
        flush();
        chk("queue_empty_a", q0.size(), 0);
        chk("queue_empty_b", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder4to2_hs.md
Name: encoder4to2_hs

Overview:
Sequential 4-to-2 priority encoder with request capture and a valid/ready output handshake. It is the inverse of the team's 2-to-4 gate-level decoder.
- Single-cycle request pulses on req[3:0] are latched into a pending register.
- The highest-priority pending request is presented as a 2-bit code; the downstream consumer accepts it via valid/ready.
- The code bit ordering matches the decoder's (i0, i1) inputs, so encoder-into-decoder round-trips are direct.

Parameters:
CNT_W, 8, width of the saturating dropped-request counter
HI_WINS, 1, 1: index 3 has highest priority; 0: index 0 has highest priority

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  capture enable; req is ignored while low
req  input  4  request pulses, one bit per source; multi-hot allowed
ready  input  1  consumer accepts code when high with valid
valid  output  1  code/multi are presenting a pending request
code  output  2  encoded index; code[1] is the decoder's i0 (MSB), code[0] is i1 (LSB)
multi  output  1  more than one bit was pending when code was selected
pending  output  4  current pending register (observability)
drop_cnt  output  CNT_W  saturating count of dropped requests

Behaviour:
Reset (async, rst_n=0):
- pending=0, valid=0, code=2'b00, multi=0, drop_cnt=0, FSM=IDLE.
- Takes effect immediately, mid-handshake included.
- After rst_n deassertion, the first capture is at the next rising edge.

Capture (every edge):
- For each k, pending[k] sets at the edge if en=1 and req[k]=1.
- req is ignored entirely while en=0; pending, the FSM and handshakes continue regardless of en.

Drop rule:
- If en=1, req[k]=1 and pending[k] is already set and is not being cleared at that same edge, the request is dropped.
- drop_cnt increments by 1 per edge in which at least one bit is dropped.
- drop_cnt saturates at all-ones with no wrap.

FSM, two states:
- IDLE: valid=0. If pending!=0 at an edge, register code = highest-priority pending index per HI_WINS; multi=1 if popcount(pending)>1; valid=1; go to HOLD. The selection uses the registered pending value, not bits captured at that same edge.
- HOLD: valid=1. code and multi are held stable while ready=0, even if higher-priority requests arrive. On an edge with ready=1: clear pending[code], valid=0, go to IDLE.

Timing:
- Latency from a req pulse in cycle N (en=1, pending empty, IDLE) to valid high is 2 edges: pending at edge N, valid at edge N+1.
- There is one idle bubble cycle (valid=0) between consecutive codes; maximum throughput is 1 code per 2 cycles.

Simultaneous events:
- req[k]=1 on the same edge that clears pending[k] via handshake: the set wins, pending[k] stays 1, and this is not a drop.
- ready is ignored in IDLE.

Priority:
- HI_WINS=1: 3 > 2 > 1 > 0.
- HI_WINS=0: 0 > 1 > 2 > 3.

Decomposition:
Package enc4_pkg holds:
- NREQ=4 and CODE_W=2.
- State enum {ST_IDLE, ST_HOLD}.
- The function popcount4.

One combinational sub-module, prio_sel4 (inputs vec[3:0] and hi_wins; outputs idx[1:0] and any), instantiated once. The top holds pending, the FSM and the counter.

Test Plan:
- Reset: rst_n=0 mid-HOLD with pending=4'b1010 -> immediately valid=0, code=00, pending=0, drop_cnt=0.
- Single request: en=1, req=4'b0100 for 1 cycle, ready=1 -> valid high 2 edges later with code=2'b10 and multi=0; valid low next cycle; pending=0.
- Multi-hot with HI_WINS=1: req=4'b1011 in one cycle, ready=1 -> codes 11, 01, 00 in order, with multi=1,1,0 and valid=0 bubbles between.
- Backpressure: ready=0 with code=01 held for 5 cycles while req=4'b1000 arrives -> code stays 01; after ready=1, the next code is 11.
- Drops, saturation and en: req[2] pulsed 3 times while pending[2]=1 and ready=0 -> drop_cnt=3. With CNT_W=2, 5 such pulses -> drop_cnt=3. With en=0, req=4'b1111 -> pending unchanged.
- Round-trip: code fed to decoder2to4 (i0=code[1], i1=code[0], en=valid) -> decoder one-hot equals the accepted req bit for all 4 indices; clear-and-set on the same edge keeps pending[k]=1 with drop_cnt unchanged.
